// File: rtl/seg7_decoder_pkg.sv
// Shared constants for the seven-segment reverse decoder: glyph codes, FSM states, counter width.
// Segment patterns are active-low, bit0 = segment a ... bit6 = segment g.
package seg7_decoder_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef logic [1:0] state_t;

    localparam state_t WAIT_HI = 2'd0;
    localparam state_t WAIT_LO = 2'd1;
    localparam state_t FULL    = 2'd2;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seg7_glyph_lookup.sv
// Combinational inverse of the hex-to-segment decoder: maps a pattern back to its digit.
// legal is low for any code that is not one of the 16 hex glyphs.
module seg7_glyph_lookup
    import seg7_decoder_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'h0;
        legal = 1'b1;
        unique case (seg_in)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_decoder.sv
// Pairs decoded seven-segment digits into bytes (high digit first) behind valid/ready handshakes.
// Counts produced bytes and rejected patterns, both saturating.
module seg7_decoder
    import seg7_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    output logic             seg_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             err,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] err_count
);

    state_t           state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic [7:0]       byte_q, byte_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic [3:0] digit;
    logic       legal;
    logic       accept;

    seg7_glyph_lookup u_lookup (
        .seg_in (seg_in),
        .digit  (digit),
        .legal  (legal)
    );

    // Gated by rst_n so the block never advertises ready while held in reset.
    assign seg_ready = rst_n & ((state_q == WAIT_HI) | (state_q == WAIT_LO));
    assign accept    = seg_valid & seg_ready;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        byte_d  = byte_q;
        bcnt_d  = bcnt_q;
        err_d   = accept & ~legal;
        ecnt_d  = (accept & ~legal) ? sat_inc(ecnt_q) : ecnt_q;
        case (state_q)
            WAIT_HI: begin
                if (accept && legal) begin
                    hi_d    = digit;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (accept) begin
                    if (legal) begin
                        byte_d  = {hi_q, digit};
                        bcnt_d  = sat_inc(bcnt_q);
                        state_d = FULL;
                    end else begin
                        // Drop the held high digit and resynchronise on the next pattern.
                        hi_d    = 4'h0;
                        state_d = WAIT_HI;
                    end
                end
            end
            FULL: begin
                if (byte_ready) begin
                    state_d = WAIT_HI;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_HI;
            hi_q    <= 4'h0;
            byte_q  <= 8'h00;
            err_q   <= 1'b0;
            bcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            bcnt_q  <= bcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = (state_q == FULL);
    assign err        = err_q;
    assign byte_count = bcnt_q;
    assign err_count  = ecnt_q;

endmodule

// File: doc/seg7_decoder.md
# seg7_decoder

Reverse path of the board's hex-to-seven-segment display decoding. Accepts active-low 7-segment patterns one digit at a time over a valid/ready handshake and maps each back to its 4-bit hex value. Pairs digits into bytes, most-significant digit first, and presents each byte on a valid/ready output. Sits between a segment-pattern source (display loopback, scan capture) and byte-oriented logic; it also counts accepted bytes and rejected patterns.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock for all state.
- Resetn  in  1  asynchronous active-low reset.
- seg_in  in  7  active-low pattern; bit0 = segment a … bit6 = segment g (0 = lit).
- seg_valid  in  1  seg_in is valid this cycle.
- seg_ready  out  1  block can accept a digit this cycle.
- byte_out  out  8  assembled byte; [7:4] = first digit, [3:0] = second.
- byte_valid  out  1  byte_out holds an unconsumed byte.
- byte_ready  in  1  consumer takes byte_out this cycle.
- err  out  1  one-cycle pulse: an accepted pattern was not a legal hex glyph.
- byte_count  out  8  bytes produced; saturates at 255.
- err_count  out  8  illegal patterns seen; saturates at 255.

## Operation
- Legal patterns (hex of seg_in → digit): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F. Every other code is illegal.
- A digit is accepted when seg_valid & seg_ready.
- The FSM has three states:
  - WAIT_HI (reset state): a legal digit is stored in the upper nibble, then go to WAIT_LO.
  - WAIT_LO: a legal digit is stored in the lower nibble, byte_valid is set, byte_count increments, then go to FULL.
  - FULL: byte_valid = 1 and the block accepts no digits. On byte_ready, byte_valid clears and the FSM returns to WAIT_HI.
- In WAIT_HI or WAIT_LO, an illegal accepted digit pulses err and increments err_count.
  - The digit is discarded.
  - Any held upper nibble is discarded and the FSM goes to WAIT_HI to resynchronise.
- seg_ready = 1 in WAIT_HI and WAIT_LO, 0 in FULL and during reset.
- byte_out is stable while byte_valid = 1 and may only change on an accepted digit.
- Both counters saturate at 255 and hold there; they never wrap.
- seg_in is ignored when seg_valid = 0. seg_valid has no effect in FULL.

## Timing
- Reset values: state WAIT_HI, seg_ready 0 while Resetn low and 1 in the first cycle after release, byte_out 8'h00, byte_valid 0, err 0, byte_count 0, err_count 0.
- Assertion of Resetn takes effect immediately from any state. Any partial byte or held byte is discarded.
- Latency: byte_valid rises in the cycle after the edge that accepts the second digit.
- err is registered and is high for exactly the one cycle after the edge that accepted the illegal pattern.
- Back-to-back: digits may be accepted on consecutive cycles in WAIT_HI and WAIT_LO.
- On the edge where byte_ready is sampled in FULL, the FSM moves to WAIT_HI and seg_ready is 1 in the next cycle. There is no same-cycle pass-through; peak throughput is one byte per 3 cycles.
- seg_ready is a function of state only, with no combinational path from seg_valid or byte_ready.
- byte_ready with byte_valid = 0 has no effect.

## Structure
- A shared package holds:
  - the 16 legal-glyph constants (SEG_0 … SEG_F, active-low, 7 bits);
  - the FSM state enum (WAIT_HI, WAIT_LO, FULL);
  - the counter width constant (8).
- One sub-module, seg7_glyph_lookup, is purely combinational: seg_in in, digit[3:0] and legal out. It is the exact inverse of the hex-to-segment decoder.
- The top level holds the FSM, nibble registers, err register and both saturating counters.

## Test plan
- Reset: hold Resetn = 0 with seg_valid = 1 → seg_ready = 0, byte_valid = 0, both counters 0; release → seg_ready = 1 in the next cycle.
- Basic pair: send 19 then 0E, byte_ready held 0 → byte_out = 8'h4F, byte_valid = 1, byte_count = 1, seg_ready = 0; assert byte_ready → byte_valid 0 and seg_ready 1 on the next cycle.
- Exhaustive glyphs: all 16 legal codes paired with 40 → each byte = {digit, 0}, err never pulses; all 112 illegal codes → 112 err pulses, err_count saturates at 255 only after extra illegal inputs, no byte produced.
- Resync: send 30, then 7F (illegal), then 02, 18 → one err pulse, byte_out = 8'h69 (the 3 is dropped).
- Backpressure: keep seg_valid = 1 with alternating codes while in FULL for 10 cycles → no digit accepted, byte_out unchanged.
- Mid-operation reset: accept 21, assert Resetn low for one cycle, then send 06, 08 → byte_out = 8'hEA, byte_count = 1.
